mem_port_arbiter: RTL

- Shares one single-port instruction/data memory between the pipeline fetch stage (IF) and the load/store stage (MEM).
- Arbitrates between the two requesters and issues accesses to a variable-latency memory.
- Returns data and a per-access valid pulse.
- Generates the stall that the pipeline control uses to freeze while an access is outstanding.
- MEM has priority over IF; a starvation counter guarantees IF progress.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (IF) and load/store (MEM) onto one variable-latency memory; MEM wins unless IF is starved.
// Access period is 2 + memory latency; requests wait (stall high) while another access is outstanding.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             discard;
  logic             if_forced;
  logic             grant_if;
  logic             grant_d;

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  assign if_forced = if_req && (starve_cnt == CNT_MAX);
  assign grant_if  = (state == IDLE) && if_req && (if_forced || !d_req);
  assign grant_d   = (state == IDLE) && d_req && !if_forced;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
        end else if (grant_if) begin
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      starve_cnt <= '0;
      discard    <= 1'b0;
    end else begin
      mem_en   <= grant_if | grant_d;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_if) begin
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end

      if (!if_req || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      // A flush in the completion cycle itself must also suppress delivery.
      if (state == BUSY_IF) begin
        if (mem_ready) begin
          if (!discard && !flush) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end
          discard <= 1'b0;
        end else if (flush) begin
          discard <= 1'b1;
        end
      end

      if ((state == BUSY_D) && mem_ready) begin
        if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
        d_valid <= 1'b1;
      end
    end
  end

endmodule
